// File: rtl/allocator_pkg.sv
// Shared header-transaction types exchanged between allocator front-ends,
// the LSU arbiter and the LSU.
package allocator_pkg;

    typedef enum logic [1:0] {
        OpLock,
        OpLoad,
        OpInsert,
        OpDelete
    } lsu_op_e;

    typedef struct packed {
        logic        val;
        lsu_op_e     lsu_op;
        logic [31:0] addr;
        logic [31:0] data;
    } header_data_req_t;

    typedef struct packed {
        logic        val;
        logic [31:0] size;
        logic [31:0] next_addr;
    } header_data_rsp_t;

endpackage

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one LSU between NUM_REQ requesters; holds the grant
// until the LSU response is handed back, with a sticky watchdog on stuck transactions.
module lsu_arbiter
    import allocator_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned GNT_W          = $clog2(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  header_data_req_t       req_i [NUM_REQ],
    output logic [NUM_REQ-1:0]     req_ack_o,
    output header_data_rsp_t       rsp_o [NUM_REQ],
    input  logic [NUM_REQ-1:0]     rsp_rdy_i,
    output header_data_req_t       lsu_req_o,
    input  logic                   lsu_ready_i,
    input  header_data_rsp_t       lsu_rsp_i,
    output logic                   lsu_rsp_rdy_o,
    output logic                   busy_o,
    output logic [GNT_W-1:0]       grant_o,
    output logic                   err_o
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e             state_q, state_d;
    logic [GNT_W-1:0]   ptr_q, ptr_d;
    logic [GNT_W-1:0]   gnt_q, gnt_d;
    header_data_req_t   req_q, req_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [WdW-1:0]     wd_q, wd_d;
    logic               err_q, err_d;

    logic               win_found;
    logic [GNT_W-1:0]   win_idx;
    logic [GNT_W-1:0]   cand_idx;
    int unsigned        cand;

    // Search starts just after the last completed grant, so it wraps to lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand     = (32'(ptr_q) + off) % NUM_REQ;
            cand_idx = GNT_W'(cand);
            if (!win_found && req_i[cand_idx].val) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        ack_d   = '0;
        wd_d    = wd_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    req_d          = req_i[win_idx];
                    gnt_d          = win_idx;
                    ack_d[win_idx] = 1'b1;
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                if (lsu_ready_i) begin
                    wd_d    = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lsu_rsp_i.val && rsp_rdy_i[gnt_q]) begin
                    ptr_d   = gnt_q;
                    state_d = StIdle;
                end else if (wd_q != WdW'(TIMEOUT_CYCLES)) begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // The stuck transaction keeps running; only the flag is raised.
        if (wd_d == WdW'(TIMEOUT_CYCLES)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= GNT_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        lsu_req_o     = req_q;
        lsu_req_o.val = (state_q == StIssue);
        lsu_rsp_rdy_o = (state_q == StWait) && rsp_rdy_i[gnt_q];
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rsp_o[k]     = lsu_rsp_i;
            rsp_o[k].val = (state_q == StWait) && (gnt_q == GNT_W'(k)) && lsu_rsp_i.val;
        end
    end

    assign req_ack_o = ack_q;
    assign busy_o    = (state_q != StIdle);
    assign grant_o   = gnt_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Randomized self-checking bench for lsu_arbiter; a transaction-level model tracks
// pending requesters, round-robin order and the watchdog flag.
module tb_lsu_arbiter;
    import allocator_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    header_data_req_t req [N];
    header_data_rsp_t rsp [N];
    logic [N-1:0]     req_ack;
    logic [N-1:0]     rsp_rdy;
    header_data_req_t lsu_req;
    logic             lsu_ready;
    header_data_rsp_t lsu_rsp;
    logic             lsu_rsp_rdy;
    logic             busy;
    logic [1:0]       grant;
    logic             err;

    always #5 clk = ~clk;

    lsu_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .req_ack_o     (req_ack),
        .rsp_o         (rsp),
        .rsp_rdy_i     (rsp_rdy),
        .lsu_req_o     (lsu_req),
        .lsu_ready_i   (lsu_ready),
        .lsu_rsp_i     (lsu_rsp),
        .lsu_rsp_rdy_o (lsu_rsp_rdy),
        .busy_o        (busy),
        .grant_o       (grant),
        .err_o         (err)
    );

    int npass  = 0;
    int ntotal = 0;

    // Reference model: who is waiting, with what payload, and where round-robin resumes.
    bit               pend [N];
    header_data_req_t pay  [N];
    int               rr_ptr = N - 1;
    bit               err_m  = 1'b0;
    int               obs_gnt;
    int               w;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick();
        for (int off = 1; off <= N; off++) begin
            if (pend[(rr_ptr + off) % N]) return (rr_ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic new_payload(input int k);
        pay[k].val    = 1'b1;
        pay[k].lsu_op = lsu_op_e'($urandom_range(3));
        pay[k].addr   = $urandom;
        pay[k].data   = $urandom;
        pend[k]       = 1'b1;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            req[k]     = pay[k];
            req[k].val = pend[k];
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        lsu_ready = 1'(($urandom_range(1)));
        drive_reqs();
        tick();
        rst           = 1'b0;
        rsp_rdy       = '1;
        lsu_rsp       = '0;
        lsu_rsp.val   = 1'b1;
        lsu_ready     = 1'b0;
        rr_ptr        = N - 1;
        err_m         = 1'b0;
        #1;
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_ack", 96'(req_ack), 96'(0));
        check("rst_grant", 96'(grant), 96'(0));
        check("rst_err", 96'(err), 96'(0));
        check("rst_lsu_val", 96'(lsu_req.val), 96'(0));
        check("rst_lsu_rsp_rdy", 96'(lsu_rsp_rdy), 96'(0));
        for (int k = 0; k < N; k++) check("rst_rsp_val", 96'(rsp[k].val), 96'(0));
        lsu_rsp.val = 1'b0;
    endtask

    // One full transaction from an IDLE cycle to the following IDLE cycle.
    // mode: 0 no requester churn, 1 random churn, 2 winner re-requests after its ack.
    task automatic txn(input int rdy_dly, input int rsp_lat, input int bp,
                       input logic [31:0] sz, input logic [31:0] nx, input int mode,
                       output int win);
        header_data_req_t exp_req;
        logic [N-1:0]     exp_ack;
        int               wcnt;
        bit               hs;

        win = rr_pick();
        drive_reqs();
        lsu_ready   = 1'b0;
        rsp_rdy     = '1;
        lsu_rsp     = '0;
        lsu_rsp.val = 1'(($urandom_range(1)));
        #1;
        check("idle_busy", 96'(busy), 96'(0));
        check("idle_ack", 96'(req_ack), 96'(0));
        check("idle_lsu_val", 96'(lsu_req.val), 96'(0));
        check("idle_lsu_rsp_rdy", 96'(lsu_rsp_rdy), 96'(0));
        check("idle_err", 96'(err), 96'(err_m));
        for (int k = 0; k < N; k++) check("idle_rsp_val", 96'(rsp[k].val), 96'(0));
        tick();

        exp_req     = pay[win];
        exp_req.val = 1'b1;
        exp_ack     = '0;
        exp_ack[win] = 1'b1;
        obs_gnt     = int'(grant);
        pend[win]   = 1'b0;
        drive_reqs();
        for (int d = 0; d <= rdy_dly; d++) begin
            lsu_ready = (d == rdy_dly);
            #1;
            check("issue_ack", 96'(req_ack), (d == 0) ? 96'(exp_ack) : 96'(0));
            check("issue_grant", 96'(grant), 96'(win));
            check("issue_busy", 96'(busy), 96'(1));
            check("issue_lsu_req", 96'(lsu_req), 96'(exp_req));
            check("issue_lsu_rsp_rdy", 96'(lsu_rsp_rdy), 96'(0));
            tick();
        end
        lsu_ready = 1'b0;

        if (mode == 2) begin
            new_payload(win);
        end else if (mode == 1) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(1) == 1) new_payload(k);
                else if (pend[k] && $urandom_range(3) == 0) pend[k] = 1'b0;
            end
        end
        drive_reqs();

        wcnt = 0;
        for (int c = 0; c <= rsp_lat + bp; c++) begin
            lsu_rsp.val       = (c >= rsp_lat);
            lsu_rsp.size      = sz;
            lsu_rsp.next_addr = nx;
            rsp_rdy           = N'($urandom);
            rsp_rdy[win]      = (c == rsp_lat + bp);
            hs                = lsu_rsp.val && rsp_rdy[win];
            #1;
            check("wait_busy", 96'(busy), 96'(1));
            check("wait_lsu_val", 96'(lsu_req.val), 96'(0));
            check("wait_lsu_rsp_rdy", 96'(lsu_rsp_rdy), 96'(rsp_rdy[win]));
            check("wait_err", 96'(err), 96'(err_m));
            for (int k = 0; k < N; k++) begin
                check("wait_rsp_val", 96'(rsp[k].val), 96'((k == win) && lsu_rsp.val));
            end
            if (lsu_rsp.val) check("wait_rsp_data", 96'(rsp[win]), 96'(lsu_rsp));
            tick();
            if (!hs) begin
                wcnt++;
                if (wcnt >= TO) err_m = 1'b1;
            end
        end
        lsu_rsp.val = 1'b0;
        rr_ptr      = win;
    endtask

    task automatic ensure_pending();
        bit any;
        any = 1'b0;
        for (int k = 0; k < N; k++) any |= pend[k];
        if (!any) new_payload(int'($urandom_range(N - 1)));
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            pay[k]  = '0;
        end
        lsu_ready = 1'b0;
        lsu_rsp   = '0;
        rsp_rdy   = '0;
        drive_reqs();
        tick();
        do_reset();

        // Single LOAD from requester 2.
        new_payload(2);
        pay[2].lsu_op = OpLoad;
        pay[2].addr   = 32'h100;
        txn(0, 2, 0, 32'h40, 32'h200, 0, w);
        check("load_grant", 96'(obs_gnt), 96'(2));

        // All requesters continuously requesting.
        do_reset();
        for (int k = 0; k < N; k++) new_payload(k);
        for (int i = 0; i < 5; i++) begin
            txn(0, $urandom_range(2), 0, $urandom, $urandom, 2, w);
            check("rr_order", 96'(obs_gnt), 96'(rr_exp[i]));
        end

        // Response backpressure on requester 1, then requester 2 wins with slow LSU ready.
        do_reset();
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        new_payload(1);
        new_payload(2);
        txn(0, 1, 3, 32'h11, 32'h22, 0, w);
        check("bp_grant", 96'(obs_gnt), 96'(1));
        txn(5, 1, 0, 32'h33, 32'h44, 0, w);
        check("after_bp_grant", 96'(obs_gnt), 96'(2));

        // Watchdog: LSU silent well past the timeout, then a late response.
        new_payload(3);
        txn(0, 12, 0, 32'h55, 32'h66, 0, w);
        check("wd_err_after", 96'(err), 96'(1));
        new_payload(0);
        txn(1, 1, 1, 32'h77, 32'h88, 0, w);
        check("wd_err_sticky", 96'(err), 96'(1));

        // Reset while in WAIT.
        for (int k = 0; k < N; k++) new_payload(k);
        drive_reqs();
        tick();
        lsu_ready = 1'b1;
        tick();
        lsu_ready = 1'b0;
        tick();
        #1;
        check("pre_rst_busy", 96'(busy), 96'(1));
        do_reset();
        for (int k = 0; k < N; k++) new_payload(k);
        txn(0, 1, 0, 32'h99, 32'haa, 0, w);
        check("post_rst_grant", 96'(obs_gnt), 96'(0));

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            ensure_pending();
            txn($urandom_range(3), $urandom_range(4), $urandom_range(3),
                $urandom, $urandom, 1, w);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
